// File: rtl/jpegls_pkg.sv
// jpegls_pkg: shared JPEG-LS coding constants.
// Golomb limits, byte-stuffing thresholds and flush FSM encoding.
package jpegls_pkg;

  localparam int LIMIT = 32;
  localparam int QBPP  = 8;
  localparam int ESC_Q = LIMIT - QBPP - 1;

  localparam logic [6:0] THR_NORM  = 7'd8;
  localparam logic [6:0] THR_STUFF = 7'd7;
  localparam logic [7:0] MARKER    = 8'hFF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRAIN = 3'd1;
  localparam logic [2:0] ST_PAD   = 3'd2;
  localparam logic [2:0] ST_FF0   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/golomb_codeword.sv
// golomb_codeword: limited-length Golomb-Rice codeword builder.
// Result is left-aligned in LIMIT bits; bits below len are zero.
module golomb_codeword #(
  parameter int LIMIT = jpegls_pkg::LIMIT,
  parameter int QBPP  = jpegls_pkg::QBPP,
  parameter int ESC_Q = jpegls_pkg::ESC_Q
) (
  input  logic [3:0]       k,
  input  logic [8:0]       MErrval,
  output logic [LIMIT-1:0] code,
  output logic [5:0]       len
);

  logic [8:0]       q;
  logic [QBPP-1:0]  m1;
  logic [LIMIT-1:0] mask;
  logic [LIMIT-1:0] body;

  always_comb begin
    q    = MErrval >> k;
    m1   = QBPP'(MErrval - 9'd1);
    mask = (LIMIT'(1) << k) - LIMIT'(1);
    if (q >= 9'(ESC_Q)) begin
      // capped unary run, then the raw sample-width value
      body = LIMIT'({1'b1, m1});
      len  = 6'(LIMIT);
    end else begin
      body = (LIMIT'(1) << k) | (LIMIT'(MErrval) & mask);
      len  = 6'(q) + 6'd1 + 6'(k);
    end
    code = body << (6'(LIMIT) - len);
  end

endmodule

// File: rtl/golomb_stream_packer.sv
// golomb_stream_packer: packs Golomb codewords MSB-first into bytes
// with 0xFF marker stuffing, backpressure and end-of-scan flush.
module golomb_stream_packer #(
  parameter int LIMIT = jpegls_pkg::LIMIT,
  parameter int QBPP  = jpegls_pkg::QBPP,
  parameter int ACC_W = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] k,
  input  logic [8:0] MErrval,
  input  logic       flush,
  output logic       ready,
  output logic [7:0] byte_out,
  output logic       en_out,
  output logic       flush_done,
  output logic       overflow
);

  import jpegls_pkg::*;

  logic [LIMIT-1:0] cw_code;
  logic [5:0]       cw_len;
  logic [LIMIT-1:0] s1_code;
  logic [5:0]       s1_len;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nx;
  logic [6:0]       fill;
  logic [6:0]       fill_nx;
  logic [6:0]       thr;
  logic [6:0]       shift;
  logic [6:0]       pos;
  logic             last_ff;
  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic             take;
  logic             drained;
  logic             emit_norm;
  logic             emit_pad;
  logic             emit_zero;
  logic             emit;
  logic [7:0]       byte_nx;

  golomb_codeword #(
    .LIMIT (LIMIT),
    .QBPP  (QBPP),
    .ESC_Q (LIMIT - QBPP - 1)
  ) u_cw (
    .k       (k),
    .MErrval (MErrval),
    .code    (cw_code),
    .len     (cw_len)
  );

  assign ready = (state == ST_IDLE) &&
                 (({1'b0, fill} + 8'(s1_len)) <= 8'(LIMIT));
  assign take = en && ready;
  assign flush_done = (state == ST_DONE);

  always_comb begin
    thr       = last_ff ? THR_STUFF : THR_NORM;
    drained   = (s1_len == 6'd0) && (fill < thr);
    emit_norm = (fill >= thr);
    emit_pad  = (state == ST_DRAIN) && drained && (fill != 7'd0);
    emit_zero = last_ff && (fill == 7'd0) && (s1_len == 6'd0) &&
                ((state == ST_DRAIN) || (state == ST_PAD));
    emit      = emit_norm || emit_pad || emit_zero;
    // after a marker only 7 data bits follow a forced zero
    byte_nx   = last_ff ? {1'b0, acc[ACC_W-1 -: 7]}
                        : acc[ACC_W-1 -: 8];
    shift     = emit_norm ? thr : 7'd0;
    pos       = fill - shift;
    acc_nx    = (acc << shift) |
                ({s1_code, {(ACC_W-LIMIT){1'b0}}} >> pos);
    fill_nx   = pos + 7'(s1_len);
    if (emit_pad) begin
      acc_nx  = '0;
      fill_nx = 7'd0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (flush) state_nx = ST_DRAIN;
      ST_DRAIN: begin
        if (drained) begin
          unique case (1'b1)
            emit_pad:  state_nx = ST_PAD;
            emit_zero: state_nx = ST_FF0;
            default:   state_nx = ST_DONE;
          endcase
        end
      end
      ST_PAD:   state_nx = emit_zero ? ST_FF0 : ST_DONE;
      ST_FF0:   state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_code  <= '0;
      s1_len   <= 6'd0;
      acc      <= '0;
      fill     <= 7'd0;
      last_ff  <= 1'b0;
      state    <= ST_IDLE;
      byte_out <= 8'h00;
      en_out   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s1_code <= take ? cw_code : '0;
      s1_len  <= take ? cw_len : 6'd0;
      acc     <= acc_nx;
      fill    <= fill_nx;
      state   <= state_nx;
      en_out  <= emit;
      if (emit) begin
        byte_out <= byte_nx;
        last_ff  <= (byte_nx == MARKER);
      end
      if (state == ST_DONE) last_ff <= 1'b0;
      if (en && !ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_golomb_stream_packer.sv
// tb_golomb_stream_packer: scoreboard bench for the Golomb byte packer.
// A bit-queue reference model predicts the stuffed byte stream.
module tb_golomb_stream_packer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] k;
  logic [8:0] merr;
  logic       flush;
  logic       ready;
  logic [7:0] byte_out;
  logic       en_out;
  logic       flush_done;
  logic       overflow;

  golomb_stream_packer dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .k          (k),
    .MErrval    (merr),
    .flush      (flush),
    .ready      (ready),
    .byte_out   (byte_out),
    .en_out     (en_out),
    .flush_done (flush_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int nbytes = 0;
  int last_cyc = 0;
  int first_cyc = 0;
  int sent_cyc = 0;
  int stalls = 0;
  bit arm = 1'b0;
  bit m_ff = 1'b0;
  bit bits[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic void m_drain();
    int thr;
    logic [7:0] b;
    thr = m_ff ? 7 : 8;
    while (bits.size() >= thr) begin
      b = 8'h00;
      for (int i = 0; i < thr; i++) b = {b[6:0], bits.pop_front()};
      exp_q.push_back(b);
      m_ff = (b == 8'hFF);
      thr = m_ff ? 7 : 8;
    end
  endfunction

  function automatic void m_push(input int kk, input int mm);
    int q;
    int m1;
    q = mm >> kk;
    m1 = mm - 1;
    if (q >= 23) begin
      for (int i = 0; i < 23; i++) bits.push_back(1'b0);
      bits.push_back(1'b1);
      for (int i = 7; i >= 0; i--) bits.push_back(m1[i]);
    end else begin
      for (int i = 0; i < q; i++) bits.push_back(1'b0);
      bits.push_back(1'b1);
      for (int i = kk - 1; i >= 0; i--) bits.push_back(mm[i]);
    end
    m_drain();
  endfunction

  function automatic void m_flush();
    int thr;
    thr = m_ff ? 7 : 8;
    if (bits.size() > 0) begin
      while (bits.size() < thr) bits.push_back(1'b0);
      m_drain();
    end
    if (m_ff) exp_q.push_back(8'h00);
    m_ff = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (en_out) begin
      nbytes++;
      last_cyc = cyc;
      if (arm) begin
        first_cyc = cyc;
        arm = 1'b0;
      end
      if (exp_q.size() == 0) chk("byte_extra", {24'd0, byte_out}, 32'h100);
      else chk("byte", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic send(input int kk, input int mm);
    int w;
    w = 0;
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w > 0) stalls++;
    if (w >= 200) chk("rdy_wait", {31'd0, ready}, 1);
    en = 1'b1;
    k = kk[3:0];
    merr = mm[8:0];
    sent_cyc = cyc;
    m_push(kk, mm);
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic do_flush(input bit empty);
    int w;
    int t0;
    w = 0;
    t0 = cyc;
    flush = 1'b1;
    m_flush();
    @(negedge clk);
    flush = 1'b0;
    while (!flush_done && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("flush_done", {31'd0, flush_done}, 1);
    if (empty) chk("done_lat_idle", cyc - t0, 2);
    else chk("done_lat", cyc - last_cyc, 1);
    chk("drained", exp_q.size(), 0);
    @(negedge clk);
    chk("done_pulse", {31'd0, flush_done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset = 1'b1;
    en = 1'b0;
    flush = 1'b0;
    k = 4'd0;
    merr = 9'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 1);
    chk("rst_en_out", {31'd0, en_out}, 0);
    chk("rst_byte", {24'd0, byte_out}, 0);
    chk("rst_done", {31'd0, flush_done}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    reset = 1'b0;
    @(negedge clk);

    do_flush(1'b1);

    repeat (8) send(0, 0);
    do_flush(1'b0);
    chk("ones_ovf", {31'd0, overflow}, 0);

    send(2, 9);
    do_flush(1'b0);

    arm = 1'b1;
    send(0, 30);
    do_flush(1'b0);
    chk("esc_lat", first_cyc - sent_cyc, 3);

    repeat (8) send(0, 0);
    send(2, 9);
    do_flush(1'b0);

    for (int i = 0; i < 24; i++)
      send($urandom_range(0, 15), $urandom_range(0, 511));
    do_flush(1'b0);

    stalls = 0;
    n0 = nbytes;
    for (int i = 0; i < 12; i++) send(0, $urandom_range(23, 200));
    do_flush(1'b0);
    chk("bp_stall", {31'd0, stalls > 0}, 1);
    chk("bp_bytes", nbytes - n0, 48);
    chk("bp_ovf", {31'd0, overflow}, 0);

    send(0, 40);
    send(0, 41);
    chk("bp_rdy_low", {31'd0, ready}, 0);
    en = 1'b1;
    k = 4'd0;
    merr = 9'd50;
    @(negedge clk);
    en = 1'b0;
    chk("ovf_set", {31'd0, overflow}, 1);
    repeat (5) @(negedge clk);
    chk("ovf_sticky", {31'd0, overflow}, 1);
    do_flush(1'b0);
    chk("ovf_after", {31'd0, overflow}, 1);

    send(0, 19);
    send(2, 9);
    reset = 1'b1;
    bits.delete();
    exp_q.delete();
    m_ff = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_en_out", {31'd0, en_out}, 0);
    chk("mid_ready", {31'd0, ready}, 1);
    chk("mid_ovf", {31'd0, overflow}, 0);
    n0 = nbytes;
    send(2, 9);
    do_flush(1'b0);
    chk("mid_bytes", nbytes - n0, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
